operand_net_interface: RTL and testbench

//  Execution-tile endpoint on the router LOCAL port (operand network, FLIT_TYPE=0).

---
 rtl/operand_net_interface_pkg.sv | 68 ++++++
 rtl/operand_net_interface_if.sv | 41 ++++
 rtl/operand_net_interface_opnd_sync_fifo.sv | 80 ++++++++
 rtl/operand_net_interface.sv | 165 ++++++++++++++++
 tb/tb_operand_net_interface.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_net_interface_pkg.sv
// Shared types for the operand-network tile endpoint.
//  - opnd_slot_e    : operand slot carried by each operand flit
//  - generic_flit_t : LOCAL-port flit payload exchanged with the router
//  - inj_state_e    : inject-side sequencing states
//  - ej_entry_t     : what the eject FIFO keeps for the reservation stations
package operand_net_interface_pkg;

    localparam int unsigned DATA_WIDTH     = 64;
    localparam int unsigned INSTR_ID_WIDTH = 7;
    localparam int unsigned NUM_TARGETS    = 2;
    localparam int unsigned EJECT_DEPTH    = 4;
    localparam int unsigned RETRY_CNT_W    = 8;
    localparam int unsigned SLOT_W         = 2;

    typedef enum logic [SLOT_W-1:0] {
        SLOT_LEFT  = 2'd0,
        SLOT_RIGHT = 2'd1,
        SLOT_PRED  = 2'd2
    } opnd_slot_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     data;
        logic [INSTR_ID_WIDTH-1:0] dest_instr;
        opnd_slot_e                slot;
        logic                      ipriority;
    } generic_flit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } inj_state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     data;
        logic [INSTR_ID_WIDTH-1:0] instr;
        opnd_slot_e                slot;
    } ej_entry_t;

    typedef struct packed {
        logic [INSTR_ID_WIDTH-1:0] instr;
        opnd_slot_e                slot;
    } tgt_sel_t;

    // Isolate the lowest set bit of a target mask.
    function automatic logic [NUM_TARGETS-1:0] lowest_bit(input logic [NUM_TARGETS-1:0] v);
        return v & (~v + NUM_TARGETS'(1));
    endfunction

    // Target ID/slot of the lowest enabled target in the mask.
    function automatic tgt_sel_t pick_target(
        input logic [NUM_TARGETS-1:0]                mask,
        input logic [NUM_TARGETS*INSTR_ID_WIDTH-1:0] ids,
        input logic [NUM_TARGETS*SLOT_W-1:0]         slots
    );
        tgt_sel_t r;
        r = '0;
        // Walk downwards so the lowest set bit is the last (winning) write.
        for (int i = int'(NUM_TARGETS) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.instr = ids[i*INSTR_ID_WIDTH +: INSTR_ID_WIDTH];
                r.slot  = opnd_slot_e'(slots[i*SLOT_W +: SLOT_W]);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/operand_net_interface_if.sv
// Signal bundle between the execution tile / router LOCAL port and the endpoint.
//  slave  : endpoint view (consumes results, ej flits, acks; drives flits and rs_*)
//  master : environment view (tile, router and reservation stations)
interface operand_net_interface_if;
    import operand_net_interface_pkg::*;

    logic                                flush;
    logic                                res_valid;
    logic                                res_ready;
    logic [DATA_WIDTH-1:0]               res_value;
    logic [NUM_TARGETS-1:0]              res_tgt_valid;
    logic [NUM_TARGETS*INSTR_ID_WIDTH-1:0] res_tgt_id;
    logic [NUM_TARGETS*SLOT_W-1:0]       res_tgt_slot;
    logic                                res_pri;
    generic_flit_t                       inj_flit;
    logic                                inj_req;
    logic                                inj_ack;
    generic_flit_t                       ej_flit;
    logic                                ej_req;
    logic                                rs_valid;
    logic                                rs_ready;
    logic [DATA_WIDTH-1:0]               rs_data;
    logic [INSTR_ID_WIDTH-1:0]           rs_instr;
    logic [SLOT_W-1:0]                   rs_slot;
    logic                                ej_overflow;
    logic [RETRY_CNT_W-1:0]              retry_cnt;

    modport slave (
        input  flush, res_valid, res_value, res_tgt_valid, res_tgt_id, res_tgt_slot,
               res_pri, inj_ack, ej_flit, ej_req, rs_ready,
        output res_ready, inj_flit, inj_req, rs_valid, rs_data, rs_instr, rs_slot,
               ej_overflow, retry_cnt
    );

    modport master (
        output flush, res_valid, res_value, res_tgt_valid, res_tgt_id, res_tgt_slot,
               res_pri, inj_ack, ej_flit, ej_req, rs_ready,
        input  res_ready, inj_flit, inj_req, rs_valid, rs_data, rs_instr, rs_slot,
               ej_overflow, retry_cnt
    );
endinterface

// File: rtl/operand_net_interface_opnd_sync_fifo.sv
// Small synchronous FIFO for the eject path.
//  clk, rst   : clock, async active-high reset
//  flush      : empty the FIFO; a concurrent push is dropped
//  push/push_data : write request (accepted when not full, or full with a pop)
//  pop        : consume head when not empty
//  head       : current head entry
//  empty/full : occupancy flags
module operand_net_interface_opnd_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic empty,
    output logic full
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    // Next-state: a pop on a full FIFO frees the slot the same cycle's push uses.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/operand_net_interface.sv
// Execution-tile endpoint on the router LOCAL port (operand network).
//  clk, rst : clock, async active-high reset
//  bus      : slave view of operand_net_interface_if
//   inject  : res_* result handshake -> one inj_flit/inj_req per enabled target,
//             resent until inj_ack; retry_cnt counts un-acked sends (saturating)
//   eject   : ej_req/ej_flit buffered, presented as rs_valid/rs_ready/rs_*;
//             ej_overflow is sticky when a flit is lost to a full buffer
//   flush   : drops all queued inject and eject traffic
module operand_net_interface
    import operand_net_interface_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    operand_net_interface_if.slave bus
);
    inj_state_e                            state_q, state_d;
    generic_flit_t                         flit_q, flit_d;
    logic [NUM_TARGETS-1:0]                pend_q, pend_d;
    logic [NUM_TARGETS*INSTR_ID_WIDTH-1:0] ids_q, ids_d;
    logic [NUM_TARGETS*SLOT_W-1:0]         slots_q, slots_d;
    logic                                  req_q, req_d;
    logic                                  res_ready_q, res_ready_d;
    logic [RETRY_CNT_W-1:0]                retry_q, retry_d;
    logic                                  ovf_q, ovf_d;
    logic [NUM_TARGETS-1:0]                pend_left;
    tgt_sel_t                              sel;

    ej_entry_t                             ej_in;
    ej_entry_t                             ej_head;
    logic                                  ej_empty, ej_full;
    logic                                  unused_ej_pri;

    // Inject sequencing: latch a result, then one req pulse per target until acked.
    always_comb begin
        state_d     = state_q;
        flit_d      = flit_q;
        pend_d      = pend_q;
        ids_d       = ids_q;
        slots_d     = slots_q;
        req_d       = 1'b0;
        res_ready_d = res_ready_q;
        retry_d     = retry_q;
        pend_left   = pend_q & ~lowest_bit(pend_q);
        sel         = '0;
        if (bus.flush) begin
            state_d     = IDLE;
            flit_d      = '0;
            pend_d      = '0;
            ids_d       = '0;
            slots_d     = '0;
            res_ready_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.res_valid && res_ready_q) begin
                        ids_d   = bus.res_tgt_id;
                        slots_d = bus.res_tgt_slot;
                        pend_d  = bus.res_tgt_valid;
                        sel     = pick_target(bus.res_tgt_valid, bus.res_tgt_id, bus.res_tgt_slot);
                        flit_d  = '{data:       bus.res_value,
                                    dest_instr: sel.instr,
                                    slot:       sel.slot,
                                    ipriority:  bus.res_pri};
                        // A result with no targets is consumed without sending.
                        if (|bus.res_tgt_valid) begin
                            state_d     = SEND;
                            req_d       = 1'b1;
                            res_ready_d = 1'b0;
                        end
                    end
                end
                SEND: begin
                    state_d = WAIT;
                end
                WAIT: begin
                    if (bus.inj_ack) begin
                        pend_d = pend_left;
                        if (|pend_left) begin
                            sel               = pick_target(pend_left, ids_q, slots_q);
                            flit_d.dest_instr = sel.instr;
                            flit_d.slot       = sel.slot;
                            state_d           = SEND;
                            req_d             = 1'b1;
                        end else begin
                            state_d     = IDLE;
                            res_ready_d = 1'b1;
                        end
                    end else begin
                        // No ack: resend the unchanged flit.
                        if (retry_q != '1) begin
                            retry_d = retry_q + RETRY_CNT_W'(1);
                        end
                        state_d = SEND;
                        req_d   = 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    res_ready_d = 1'b1;
                end
            endcase
        end
    end

    // Overflow only when the flit is truly lost (a same-cycle pop would make room).
    always_comb begin
        ovf_d = ovf_q | (bus.ej_req && ej_full && !bus.rs_ready && !bus.flush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            flit_q      <= '0;
            pend_q      <= '0;
            ids_q       <= '0;
            slots_q     <= '0;
            req_q       <= 1'b0;
            res_ready_q <= 1'b1;
            retry_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flit_q      <= flit_d;
            pend_q      <= pend_d;
            ids_q       <= ids_d;
            slots_q     <= slots_d;
            req_q       <= req_d;
            res_ready_q <= res_ready_d;
            retry_q     <= retry_d;
            ovf_q       <= ovf_d;
        end
    end

    // Priority is meaningless once the flit has left the network.
    assign unused_ej_pri = bus.ej_flit.ipriority;
    assign ej_in = '{data:  bus.ej_flit.data,
                     instr: bus.ej_flit.dest_instr,
                     slot:  bus.ej_flit.slot};

    operand_net_interface_opnd_sync_fifo #(
        .DEPTH (EJECT_DEPTH),
        .T     (ej_entry_t)
    ) u_ej_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .push      (bus.ej_req),
        .push_data (ej_in),
        .pop       (bus.rs_ready),
        .head      (ej_head),
        .empty     (ej_empty),
        .full      (ej_full)
    );

    assign bus.res_ready   = res_ready_q;
    assign bus.inj_req     = req_q;
    assign bus.inj_flit    = flit_q;
    assign bus.retry_cnt   = retry_q;
    assign bus.ej_overflow = ovf_q;
    assign bus.rs_valid    = !ej_empty;
    assign bus.rs_data     = ej_head.data;
    assign bus.rs_instr    = ej_head.instr;
    assign bus.rs_slot     = ej_head.slot;

endmodule

// File: tb/tb_operand_net_interface.sv
// Bench for operand_net_interface: transaction-level model (queue of flits still
// owed to the router, queue of flits owed to the reservation stations) checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_operand_net_interface;
    import operand_net_interface_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    operand_net_interface_if bus();

    operand_net_interface dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    generic_flit_t exp_q[$];   // flits still to be delivered, in send order
    generic_flit_t ej_q[$];    // flits waiting for the reservation stations
    bit            m_req;      // req expected in the current cycle
    bit            m_ovf;
    int            m_retry;

    // Directed-test bookkeeping
    int            req_cyc[$];
    int            req_dst[$];
    logic [63:0]   got[$];
    int            ready_cyc, waits, sends_a, sends_b, nreq;
    bit            done;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        ej_q.delete();
        m_req   = 1'b0;
        m_ovf   = 1'b0;
        m_retry = 0;
    endtask

    function automatic bit model_in_wait();
        return (exp_q.size() > 0) && !m_req;
    endfunction

    // Advance the model over one clock edge using the inputs seen at that edge.
    task automatic model_update();
        int pend_pre;
        bit req_pre;
        bit in_wait;
        pend_pre = exp_q.size();
        req_pre  = m_req;
        in_wait  = (pend_pre > 0) && !req_pre;
        if (bus.flush) begin
            exp_q.delete();
            ej_q.delete();
            m_req = 1'b0;
        end else begin
            if (in_wait) begin
                if (bus.inj_ack) void'(exp_q.pop_front());
                else if (m_retry < 255) m_retry++;
            end
            if (pend_pre == 0 && bus.res_valid) begin
                for (int i = 0; i < 2; i++) begin
                    if (bus.res_tgt_valid[i]) begin
                        generic_flit_t f;
                        f.data       = bus.res_value;
                        f.dest_instr = bus.res_tgt_id[i*7 +: 7];
                        f.slot       = opnd_slot_e'(bus.res_tgt_slot[i*2 +: 2]);
                        f.ipriority  = bus.res_pri;
                        exp_q.push_back(f);
                    end
                end
            end
            m_req = (exp_q.size() > 0) && !req_pre;
            if (ej_q.size() > 0 && bus.rs_ready) void'(ej_q.pop_front());
            if (bus.ej_req) begin
                if (ej_q.size() < 4) ej_q.push_back(bus.ej_flit);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("res_ready", 128'(bus.res_ready), 128'(exp_q.size() == 0));
        chk("inj_req", 128'(bus.inj_req), 128'(m_req));
        if (exp_q.size() > 0) chk("inj_flit", 128'(bus.inj_flit), 128'(exp_q[0]));
        chk("retry_cnt", 128'(bus.retry_cnt), 128'(m_retry));
        chk("rs_valid", 128'(bus.rs_valid), 128'(ej_q.size() > 0));
        if (ej_q.size() > 0) begin
            chk("rs_data", 128'(bus.rs_data), 128'(ej_q[0].data));
            chk("rs_instr", 128'(bus.rs_instr), 128'(ej_q[0].dest_instr));
            chk("rs_slot", 128'(bus.rs_slot), 128'(ej_q[0].slot));
        end
        chk("ej_overflow", 128'(bus.ej_overflow), 128'(m_ovf));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_update();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        bus.flush         = 1'b0;
        bus.res_valid     = 1'b0;
        bus.res_value     = '0;
        bus.res_tgt_valid = '0;
        bus.res_tgt_id    = '0;
        bus.res_tgt_slot  = '0;
        bus.res_pri       = 1'b0;
        bus.inj_ack       = 1'b0;
        bus.ej_flit       = '0;
        bus.ej_req        = 1'b0;
        bus.rs_ready      = 1'b0;
    endtask

    task automatic reset_pulse();
        idle_inputs();
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic offer(input logic [63:0] v, input logic [1:0] tv,
                         input logic [6:0] id0, input logic [1:0] s0,
                         input logic [6:0] id1, input logic [1:0] s1, input logic pri);
        bus.res_valid     = 1'b1;
        bus.res_value     = v;
        bus.res_tgt_valid = tv;
        bus.res_tgt_id    = {id1, id0};
        bus.res_tgt_slot  = {s1, s0};
        bus.res_pri       = pri;
    endtask

    task automatic ej_push(input int d);
        bus.ej_flit.data       = 64'(d);
        bus.ej_flit.dest_instr = 7'(d);
        bus.ej_flit.slot       = opnd_slot_e'(2'(d % 3));
        bus.ej_flit.ipriority  = 1'(d);
        bus.ej_req             = 1'b1;
        cycle();
        bus.ej_req = 1'b0;
    endtask

    task automatic drain();
        got.delete();
        bus.rs_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (bus.rs_valid) got.push_back(bus.rs_data);
            cycle();
        end
        bus.rs_ready = 1'b0;
    endtask

    function automatic logic [63:0] got_at(input int i);
        return (i < got.size()) ? got[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    initial begin
        idle_inputs();
        model_reset();

        // ---- 1: two targets, acked every WAIT ----
        reset_pulse();
        chk("rst_res_ready", 128'(bus.res_ready), 128'(1));
        chk("rst_inj_req", 128'(bus.inj_req), 128'(0));
        chk("rst_inj_flit", 128'(bus.inj_flit), 128'(0));
        chk("rst_rs_valid", 128'(bus.rs_valid), 128'(0));
        chk("rst_ovf", 128'(bus.ej_overflow), 128'(0));
        chk("rst_retry", 128'(bus.retry_cnt), 128'(0));
        offer(64'h0123_4567_89AB_CDEF, 2'b11, 7'd5, 2'd0, 7'd9, 2'd1, 1'b1);
        cycle();
        bus.res_valid = 1'b0;
        req_cyc.delete();
        req_dst.delete();
        ready_cyc = -1;
        for (int c = 1; c <= 8; c++) begin
            if (bus.inj_req) begin
                req_cyc.push_back(c);
                req_dst.push_back(int'(bus.inj_flit.dest_instr));
            end
            if (bus.res_ready && ready_cyc < 0) ready_cyc = c;
            bus.inj_ack = model_in_wait();
            cycle();
        end
        bus.inj_ack = 1'b0;
        chk("t1_nreq", 128'(req_cyc.size()), 128'(2));
        chk("t1_req0_cyc", 128'((req_cyc.size() > 0) ? req_cyc[0] : -1), 128'(1));
        chk("t1_req1_cyc", 128'((req_cyc.size() > 1) ? req_cyc[1] : -1), 128'(3));
        chk("t1_dst0", 128'((req_dst.size() > 0) ? req_dst[0] : -1), 128'(5));
        chk("t1_dst1", 128'((req_dst.size() > 1) ? req_dst[1] : -1), 128'(9));
        // SEND,WAIT,SEND,WAIT occupy cycles 1..4; ready again in the next cycle.
        chk("t1_ready_cyc", 128'(ready_cyc), 128'(5));

        // ---- 2: three un-acked WAITs on the first target ----
        reset_pulse();
        offer(64'hAAAA_0000_5555_FFFF, 2'b11, 7'd20, 2'd2, 7'd21, 2'd0, 1'b0);
        cycle();
        bus.res_valid = 1'b0;
        waits = 0; sends_a = 0; sends_b = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (bus.inj_req) begin
                if (bus.inj_flit.dest_instr == 7'd20) sends_a++;
                else sends_b++;
            end
            if (model_in_wait()) begin
                bus.inj_ack = (waits >= 3);
                waits++;
            end else begin
                bus.inj_ack = 1'b0;
            end
            cycle();
            if (bus.res_ready) done = 1'b1;
        end
        bus.inj_ack = 1'b0;
        chk("t2_done", 128'(done), 128'(1));
        chk("t2_sends_first", 128'(sends_a), 128'(4));
        chk("t2_sends_second", 128'(sends_b), 128'(1));
        chk("t2_retry", 128'(bus.retry_cnt), 128'(3));

        // ---- 3: five ejects into a 4-deep buffer, then drain ----
        reset_pulse();
        for (int k = 0; k < 5; k++) begin
            ej_push(100 + k);
            cycle();
        end
        chk("t3_ovf", 128'(bus.ej_overflow), 128'(1));
        drain();
        chk("t3_count", 128'(got.size()), 128'(4));
        for (int k = 0; k < 4; k++) chk("t3_order", 128'(got_at(k)), 128'(100 + k));

        // ---- 4: push and pop together on a full buffer ----
        reset_pulse();
        for (int k = 0; k < 4; k++) ej_push(200 + k);
        bus.rs_ready = 1'b1;
        ej_push(204);
        bus.rs_ready = 1'b0;
        chk("t4_ovf", 128'(bus.ej_overflow), 128'(0));
        chk("t4_head", 128'(bus.rs_data), 128'(201));
        drain();
        chk("t4_count", 128'(got.size()), 128'(4));
        for (int k = 0; k < 4; k++) chk("t4_order", 128'(got_at(k)), 128'(201 + k));

        // ---- 5: flush in WAIT with the second target still pending ----
        reset_pulse();
        ej_push(300);
        ej_push(301);
        offer(64'h1111_2222_3333_4444, 2'b11, 7'd40, 2'd1, 7'd41, 2'd2, 1'b0);
        cycle();
        bus.res_valid = 1'b0;
        cycle();
        chk("t5_in_wait_req", 128'(bus.inj_req), 128'(0));
        chk("t5_in_wait_ready", 128'(bus.res_ready), 128'(0));
        bus.flush   = 1'b1;
        bus.inj_ack = 1'b1;
        cycle();
        bus.flush   = 1'b0;
        bus.inj_ack = 1'b0;
        chk("t5_ready", 128'(bus.res_ready), 128'(1));
        chk("t5_rs_valid", 128'(bus.rs_valid), 128'(0));
        nreq = 0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            if (bus.inj_req) nreq++;
        end
        chk("t5_no_req", 128'(nreq), 128'(0));
        chk("t5_retry_kept", 128'(bus.retry_cnt), 128'(0));

        // ---- 6: async reset in the middle of a resend ----
        reset_pulse();
        for (int k = 0; k < 5; k++) ej_push(400 + k);
        offer(64'hCAFE_F00D_0000_0001, 2'b10, 7'd0, 2'd0, 7'd77, 2'd1, 1'b1);
        cycle();
        bus.res_valid = 1'b0;
        cycle();
        cycle();
        chk("t6_resend_req", 128'(bus.inj_req), 128'(1));
        chk("t6_retry_pre", 128'(bus.retry_cnt), 128'(1));
        chk("t6_ovf_pre", 128'(bus.ej_overflow), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_req", 128'(bus.inj_req), 128'(0));
        chk("t6_async_ready", 128'(bus.res_ready), 128'(1));
        chk("t6_async_flit", 128'(bus.inj_flit), 128'(0));
        chk("t6_async_rs_valid", 128'(bus.rs_valid), 128'(0));
        chk("t6_async_ovf", 128'(bus.ej_overflow), 128'(0));
        chk("t6_async_retry", 128'(bus.retry_cnt), 128'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        chk("t6_ready_after", 128'(bus.res_ready), 128'(1));

        // ---- 7: retry counter saturation ----
        reset_pulse();
        offer(64'h0, 2'b01, 7'd3, 2'd0, 7'd0, 2'd0, 1'b0);
        cycle();
        bus.res_valid = 1'b0;
        for (int c = 0; c < 600; c++) cycle();
        chk("t7_retry_sat", 128'(bus.retry_cnt), 128'(255));
        for (int c = 0; c < 4; c++) begin
            bus.inj_ack = model_in_wait();
            cycle();
        end
        bus.inj_ack = 1'b0;
        chk("t7_done", 128'(bus.res_ready), 128'(1));

        // ---- random traffic ----
        reset_pulse();
        for (int c = 0; c < 3000; c++) begin
            bus.flush         = ($urandom_range(63) == 0);
            bus.res_valid     = !bus.flush && ($urandom_range(2) == 0);
            bus.res_value     = {$urandom, $urandom};
            bus.res_tgt_valid = 2'($urandom);
            bus.res_tgt_id    = 14'($urandom);
            bus.res_tgt_slot  = {2'($urandom_range(2)), 2'($urandom_range(2))};
            bus.res_pri       = 1'($urandom);
            bus.inj_ack       = model_in_wait() && ($urandom_range(3) != 0);
            bus.ej_req        = ($urandom_range(2) == 0);
            bus.ej_flit.data       = {$urandom, $urandom};
            bus.ej_flit.dest_instr = 7'($urandom);
            bus.ej_flit.slot       = opnd_slot_e'(2'($urandom_range(2)));
            bus.ej_flit.ipriority  = 1'($urandom);
            bus.rs_ready      = ($urandom_range(1) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
